// File: rtl/bp_fe_controller_mt.sv
// Multithreaded front-end fetch controller: one reset/wait/run/resume FSM per thread,
// round-robin fetch arbitration, per-thread in-flight credits and stale-return dropping.
module bp_fe_controller_mt #(
    parameter int  threads_p     = 2,
    parameter int  vaddr_width_p = 39,
    parameter int  outstanding_p = 2,
    localparam int tid_width_lp  = (threads_p > 1) ? $clog2(threads_p) : 1,
    localparam int cnt_width_lp  = $clog2(outstanding_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       init_done_i,
    input  logic                       cmd_v_i,
    input  logic [tid_width_lp-1:0]    cmd_tid_i,
    input  logic [2:0]                 cmd_op_i,
    input  logic [vaddr_width_p-1:0]   cmd_npc_i,
    output logic                       cmd_yumi_o,
    output logic                       redirect_v_o,
    output logic [tid_width_lp-1:0]    redirect_tid_o,
    output logic [vaddr_width_p-1:0]   redirect_npc_o,
    output logic                       fetch_v_o,
    output logic [tid_width_lp-1:0]    fetch_tid_o,
    input  logic                       fetch_yumi_i,
    input  logic                       ret_v_i,
    input  logic [tid_width_lp-1:0]    ret_tid_i,
    input  logic                       ret_exc_i,
    input  logic [vaddr_width_p-1:0]   ret_pc_i,
    input  logic [31:0]                ret_instr_i,
    output logic                       fe_queue_v_o,
    output logic [tid_width_lp-1:0]    fe_queue_tid_o,
    output logic                       fe_queue_exc_o,
    output logic [vaddr_width_p-1:0]   fe_queue_pc_o,
    output logic [31:0]                fe_queue_instr_o,
    input  logic                       fe_queue_ready_and_i,
    output logic [2*threads_p-1:0]     thread_state_o
);

    // Handshakes: a command transfers when cmd_v_i && cmd_yumi_o; a fetch issues when
    // fetch_v_o && fetch_yumi_i; a forwarded return is always accepted by the FE queue.
    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_WAIT   = 2'd1,
        S_RUN    = 2'd2,
        S_RESUME = 2'd3
    } state_e;

    typedef logic [tid_width_lp-1:0] tid_t;
    typedef logic [cnt_width_lp-1:0] cnt_t;

    localparam cnt_t       OUT_MAX         = cnt_t'(outstanding_p);
    localparam logic [2:0] OP_STATE_RESET  = 3'd0;
    localparam logic [2:0] OP_PC_REDIRECT  = 3'd1;
    localparam logic [2:0] OP_FILL_RESTART = 3'd2;
    localparam logic [2:0] OP_WAIT         = 3'd3;
    localparam logic [2:0] OP_FENCE        = 3'd4;
    localparam logic [2:0] OP_ATTABOY      = 3'd5;

    state_e state_q [threads_p];
    state_e state_d [threads_p];
    cnt_t   ocnt_q  [threads_p];
    cnt_t   ocnt_d  [threads_p];
    cnt_t   dcnt_q  [threads_p];
    cnt_t   dcnt_d  [threads_p];
    tid_t   rr_q, rr_d;

    logic [threads_p-1:0] cmd_hit, cmd_blk, ret_hit, elig;
    logic                 cmd_fire, grant_v, issue_v, fwd_v, redir_v;
    tid_t                 grant_tid;

    always_comb begin
        int unsigned idx;
        tid_t        idx_tid;
        idx       = 0;
        idx_tid   = '0;
        cmd_fire  = cmd_v_i && !reset_i && ((cmd_op_i != OP_STATE_RESET) || init_done_i);
        grant_v   = 1'b0;
        grant_tid = '0;
        for (int t = 0; t < threads_p; t++) begin
            cmd_hit[t] = cmd_fire && (cmd_tid_i == tid_t'(t));
            cmd_blk[t] = cmd_hit[t] && (cmd_op_i != OP_ATTABOY);
            ret_hit[t] = ret_v_i && !reset_i && (ret_tid_i == tid_t'(t));
            elig[t]    = ((state_q[t] == S_RUN) || (state_q[t] == S_RESUME))
                         && (ocnt_q[t] < OUT_MAX) && !cmd_blk[t]
                         && fe_queue_ready_and_i && !reset_i;
        end
        // Search starts one past the last granted thread and wraps.
        for (int i = 1; i <= threads_p; i++) begin
            idx = 32'(rr_q) + 32'(i);
            if (idx >= threads_p) idx = idx - threads_p;
            idx_tid = tid_t'(idx);
            if (!grant_v && elig[idx_tid]) begin
                grant_v   = 1'b1;
                grant_tid = idx_tid;
            end
        end
    end

    always_comb begin
        logic issue_t, ret_dec, fwd_t;
        issue_t = 1'b0;
        ret_dec = 1'b0;
        fwd_t   = 1'b0;
        issue_v = grant_v && fetch_yumi_i;
        fwd_v   = 1'b0;
        redir_v = 1'b0;
        rr_d    = issue_v ? grant_tid : rr_q;
        for (int t = 0; t < threads_p; t++) begin
            state_d[t] = state_q[t];
            dcnt_d[t]  = dcnt_q[t];
            issue_t    = issue_v && (grant_tid == tid_t'(t));
            ret_dec    = ret_hit[t] && (ocnt_q[t] != '0);
            ocnt_d[t]  = ocnt_q[t] + cnt_t'(issue_t) - cnt_t'(ret_dec);
            fwd_t      = ret_hit[t] && (state_q[t] != S_RESET) && (dcnt_q[t] == '0) && !cmd_blk[t];
            fwd_v      = fwd_v || fwd_t;

            if (ret_hit[t] && !fwd_t && (dcnt_q[t] != '0)) dcnt_d[t] = dcnt_q[t] - 1'b1;
            if (issue_t && (state_q[t] == S_RESUME)) state_d[t] = S_RUN;
            // Everything still in flight after a faulting return belongs to the dead path.
            if (fwd_t && ret_exc_i) begin
                state_d[t] = S_WAIT;
                dcnt_d[t]  = ocnt_d[t];
            end
            if (cmd_hit[t]) begin
                if (cmd_op_i == OP_STATE_RESET) begin
                    state_d[t] = S_RESUME;
                    dcnt_d[t]  = ocnt_d[t];
                end else if (state_q[t] != S_RESET) begin
                    case (cmd_op_i)
                        OP_PC_REDIRECT, OP_FILL_RESTART: begin
                            state_d[t] = S_RUN;
                            dcnt_d[t]  = ocnt_d[t];
                            redir_v    = 1'b1;
                        end
                        OP_WAIT: begin
                            state_d[t] = S_WAIT;
                            dcnt_d[t]  = ocnt_d[t];
                        end
                        OP_FENCE: begin
                            state_d[t] = S_WAIT;
                            dcnt_d[t]  = ocnt_d[t];
                            redir_v    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int t = 0; t < threads_p; t++) begin
                state_q[t] <= S_RESET;
                ocnt_q[t]  <= '0;
                dcnt_q[t]  <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int t = 0; t < threads_p; t++) begin
                state_q[t] <= state_d[t];
                ocnt_q[t]  <= ocnt_d[t];
                dcnt_q[t]  <= dcnt_d[t];
            end
            rr_q <= rr_d;
        end
    end

    always @(posedge clk_i) begin
        for (int t = 0; t < threads_p; t++) begin
            if (ret_hit[t] && (state_q[t] != S_RESET)) assert (ocnt_q[t] != '0);
        end
    end

    assign cmd_yumi_o       = cmd_fire;
    assign redirect_v_o     = redir_v;
    assign redirect_tid_o   = redir_v ? cmd_tid_i : '0;
    assign redirect_npc_o   = redir_v ? cmd_npc_i : '0;
    assign fetch_v_o        = grant_v;
    assign fetch_tid_o      = grant_tid;
    assign fe_queue_v_o     = fwd_v;
    assign fe_queue_tid_o   = reset_i ? '0 : ret_tid_i;
    assign fe_queue_exc_o   = !reset_i && ret_exc_i;
    assign fe_queue_pc_o    = reset_i ? '0 : ret_pc_i;
    assign fe_queue_instr_o = reset_i ? '0 : ret_instr_i;

    always_comb begin
        thread_state_o = '0;
        for (int t = 0; t < threads_p; t++) thread_state_o[2*t +: 2] = state_q[t];
    end

endmodule

// File: tb/tb_bp_fe_controller_mt.sv
// Bench for bp_fe_controller_mt: directed steps then random traffic, checked against an
// epoch-tagged in-flight fetch list per thread.
module tb_bp_fe_controller_mt;

    localparam int THR = 2;
    localparam int VA  = 39;
    localparam int OUT = 2;
    localparam int TW  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done, cmd_v, fetch_yumi, ret_v, ret_exc, fe_ready;
    logic [TW-1:0] cmd_tid, ret_tid;
    logic [2:0]    cmd_op;
    logic [VA-1:0] cmd_npc, ret_pc;
    logic [31:0]   ret_instr;

    logic              cmd_yumi, redirect_v, fetch_v, fe_v, fe_exc;
    logic [TW-1:0]     redirect_tid, fetch_tid, fe_tid;
    logic [VA-1:0]     redirect_npc, fe_pc;
    logic [31:0]       fe_instr;
    logic [2*THR-1:0]  thread_state;

    always #5 clk = ~clk;

    bp_fe_controller_mt #(.threads_p(THR), .vaddr_width_p(VA), .outstanding_p(OUT)) dut (
        .clk_i(clk), .reset_i(rst), .init_done_i(init_done),
        .cmd_v_i(cmd_v), .cmd_tid_i(cmd_tid), .cmd_op_i(cmd_op), .cmd_npc_i(cmd_npc),
        .cmd_yumi_o(cmd_yumi),
        .redirect_v_o(redirect_v), .redirect_tid_o(redirect_tid), .redirect_npc_o(redirect_npc),
        .fetch_v_o(fetch_v), .fetch_tid_o(fetch_tid), .fetch_yumi_i(fetch_yumi),
        .ret_v_i(ret_v), .ret_tid_i(ret_tid), .ret_exc_i(ret_exc),
        .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .fe_queue_v_o(fe_v), .fe_queue_tid_o(fe_tid), .fe_queue_exc_o(fe_exc),
        .fe_queue_pc_o(fe_pc), .fe_queue_instr_o(fe_instr),
        .fe_queue_ready_and_i(fe_ready), .thread_state_o(thread_state)
    );

    // Reference: each issued fetch remembers its thread's epoch at issue time; any
    // redirect/wait/reset command or faulting return opens a new epoch, so older fetches
    // are stale and returns of stale fetches never reach the FE queue.
    typedef struct {
        int tid;
        int ep;
    } fl_t;

    fl_t fl_q[$];
    int  m_state [THR];
    int  m_epoch [THR];
    int  m_rr;
    int  n_checks = 0;
    int  n_errors = 0;

    bit  e_yumi, e_fv, e_rv, e_fwd;
    int  e_ft;
    bit  blocked [THR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int inflight(input int t);
        int n = 0;
        foreach (fl_q[i]) if (fl_q[i].tid == t) n++;
        return n;
    endfunction

    function automatic int front_idx(input int t);
        for (int i = 0; i < fl_q.size(); i++) if (fl_q[i].tid == t) return i;
        return -1;
    endfunction

    task automatic model_reset();
        fl_q.delete();
        for (int t = 0; t < THR; t++) m_state[t] = 0;
        m_rr = 0;
    endtask

    task automatic eval();
        int fi;
        e_yumi = cmd_v && ((cmd_op != 3'd0) || init_done);
        for (int t = 0; t < THR; t++) blocked[t] = e_yumi && (int'(cmd_tid) == t) && (cmd_op != 3'd5);
        e_fv = 1'b0;
        e_ft = 0;
        for (int i = 1; i <= THR; i++) begin
            int idx = (m_rr + i) % THR;
            if (!e_fv && (m_state[idx] == 2 || m_state[idx] == 3) && inflight(idx) < OUT
                && !blocked[idx] && fe_ready) begin
                e_fv = 1'b1;
                e_ft = idx;
            end
        end
        e_rv = e_yumi && (m_state[cmd_tid] != 0)
               && (cmd_op == 3'd1 || cmd_op == 3'd2 || cmd_op == 3'd4);
        fi = front_idx(int'(ret_tid));
        e_fwd = ret_v && (m_state[ret_tid] != 0) && (fi >= 0) && !blocked[ret_tid];
        if (e_fwd) e_fwd = (fl_q[fi].ep == m_epoch[ret_tid]);
    endtask

    task automatic check_outputs();
        logic [2*THR-1:0] ts;
        ts = '0;
        for (int t = 0; t < THR; t++) ts[2*t +: 2] = 2'(m_state[t]);
        chk("cmd_yumi", cmd_yumi, e_yumi);
        chk("redirect_v", redirect_v, e_rv);
        if (e_rv) begin
            chk("redirect_tid", redirect_tid, cmd_tid);
            chk("redirect_npc", redirect_npc, cmd_npc);
        end
        chk("fetch_v", fetch_v, e_fv);
        if (e_fv) chk("fetch_tid", fetch_tid, e_ft);
        chk("fe_queue_v", fe_v, e_fwd);
        if (e_fwd) begin
            chk("fe_queue_tid", fe_tid, ret_tid);
            chk("fe_queue_exc", fe_exc, ret_exc);
            chk("fe_queue_pc", fe_pc, ret_pc);
            chk("fe_queue_instr", fe_instr, ret_instr);
        end
        chk("thread_state", thread_state, ts);
    endtask

    task automatic commit();
        int  fi;
        int  t;
        fl_t f;
        if (ret_v) begin
            fi = front_idx(int'(ret_tid));
            if (fi >= 0) fl_q.delete(fi);
        end
        if (e_fv && fetch_yumi) begin
            f.tid = e_ft;
            f.ep  = m_epoch[e_ft];
            fl_q.push_back(f);
            if (m_state[e_ft] == 3) m_state[e_ft] = 2;
            m_rr = e_ft;
        end
        if (e_fwd && ret_exc) begin
            m_state[ret_tid] = 1;
            m_epoch[ret_tid]++;
        end
        if (e_yumi) begin
            t = int'(cmd_tid);
            if (cmd_op == 3'd0) begin
                m_state[t] = 3;
                m_epoch[t]++;
            end else if (m_state[t] != 0) begin
                if (cmd_op == 3'd1 || cmd_op == 3'd2) begin
                    m_state[t] = 2;
                    m_epoch[t]++;
                end else if (cmd_op == 3'd3 || cmd_op == 3'd4) begin
                    m_state[t] = 1;
                    m_epoch[t]++;
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        eval();
        check_outputs();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic set_idle();
        cmd_v = 1'b0; cmd_tid = '0; cmd_op = 3'd0; cmd_npc = '0;
        fetch_yumi = 1'b0; ret_v = 1'b0; ret_tid = '0; ret_exc = 1'b0;
        ret_pc = '0; ret_instr = '0; fe_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_v = 1'b1; cmd_tid = 1'b1; cmd_op = 3'd1; cmd_npc = 39'h12_3456_789a;
        fetch_yumi = 1'b1; ret_v = 1'b1; ret_tid = 1'b1; ret_exc = 1'b1;
        ret_pc = 39'h0a_bcde_f012; ret_instr = 32'hdead_beef; fe_ready = 1'b1;
        #1;
        chk("rst_cmd_yumi", cmd_yumi, 0);
        chk("rst_redirect_v", redirect_v, 0);
        chk("rst_redirect_tid", redirect_tid, 0);
        chk("rst_redirect_npc", redirect_npc, 0);
        chk("rst_fetch_v", fetch_v, 0);
        chk("rst_fetch_tid", fetch_tid, 0);
        chk("rst_fe_v", fe_v, 0);
        chk("rst_fe_tid", fe_tid, 0);
        chk("rst_fe_exc", fe_exc, 0);
        chk("rst_fe_pc", fe_pc, 0);
        chk("rst_fe_instr", fe_instr, 0);
        chk("rst_thread_state", thread_state, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        int          t;
        rst = 1'b0;
        init_done = 1'b0;
        for (int i = 0; i < THR; i++) m_epoch[i] = 0;
        set_idle();
        @(negedge clk);
        do_reset();

        // state_reset held until init completes, then t0 resumes and first issue -> RUN
        set_idle(); cmd_v = 1'b1; cmd_op = 3'd0; cmd_tid = 1'b0;
        #1 chk("sr_held_yumi", cmd_yumi, 0);
        cycle();
        init_done = 1'b1;
        cycle();
        set_idle();
        chk("t0_resume", thread_state, 4'h3);
        fetch_yumi = 1'b1;
        cycle();
        chk("t0_run", thread_state, 4'h2);

        // bring up t1, then issue until every credit is used
        set_idle(); cmd_v = 1'b1; cmd_op = 3'd0; cmd_tid = 1'b1;
        cycle();
        set_idle(); fetch_yumi = 1'b1;
        repeat (4) cycle();
        chk("credits_exhausted", fetch_v, 0);
        chk("both_run", thread_state, 4'ha);

        // redirect t1 with two in flight: both old returns dropped, the next one forwarded
        set_idle(); cmd_v = 1'b1; cmd_op = 3'd1; cmd_tid = 1'b1; cmd_npc = 39'h00_8000_0000;
        #1 chk("redir_v", redirect_v, 1);
        chk("redir_npc", redirect_npc, 39'h00_8000_0000);
        cycle();
        set_idle(); ret_v = 1'b1; ret_tid = 1'b1; ret_pc = 39'h100;
        repeat (2) cycle();
        set_idle(); fetch_yumi = 1'b1;
        cycle();
        set_idle(); ret_v = 1'b1; ret_tid = 1'b1; ret_pc = 39'h00_8000_0000; ret_instr = 32'h0000_0013;
        #1 chk("t1_fwd_after_drops", fe_v, 1);
        cycle();

        // faulting return on t0 with another in flight
        set_idle(); ret_v = 1'b1; ret_tid = 1'b0; ret_exc = 1'b1; ret_pc = 39'h2000; ret_instr = 32'h1234_5678;
        #1 chk("exc_fwd_v", fe_v, 1);
        chk("exc_fwd_exc", fe_exc, 1);
        cycle();
        chk("t0_wait", thread_state, 4'h9);
        set_idle(); ret_v = 1'b1; ret_tid = 1'b0;
        #1 chk("t0_stale_drop", fe_v, 0);
        cycle();
        set_idle(); fetch_yumi = 1'b1;
        repeat (3) cycle();
        set_idle(); ret_v = 1'b1; ret_tid = 1'b1; ret_pc = 39'h3000;
        cycle();

        // no issue without downstream room; attaboy leaves state alone
        set_idle(); fe_ready = 1'b0; fetch_yumi = 1'b1;
        #1 chk("not_ready_no_fetch", fetch_v, 0);
        cycle();
        set_idle(); cmd_v = 1'b1; cmd_op = 3'd5; cmd_tid = 1'b1;
        #1 chk("attaboy_yumi", cmd_yumi, 1);
        cycle();
        chk("attaboy_state", thread_state, 4'h9);

        // command and return for t1 in the same cycle: command wins
        set_idle(); cmd_v = 1'b1; cmd_op = 3'd3; cmd_tid = 1'b1; ret_v = 1'b1; ret_tid = 1'b1;
        #1 chk("cmd_beats_ret", fe_v, 0);
        cycle();
        chk("both_wait", thread_state, 4'h5);

        // reset in the middle of a fetch burst
        set_idle(); cmd_v = 1'b1; cmd_op = 3'd1; cmd_tid = 1'b0; cycle();
        set_idle(); cmd_v = 1'b1; cmd_op = 3'd2; cmd_tid = 1'b1; cycle();
        set_idle(); fetch_yumi = 1'b1;
        repeat (2) cycle();
        do_reset();
        set_idle(); ret_v = 1'b1; ret_tid = 1'b0; ret_pc = 39'h4000;
        #1 chk("post_reset_ret_drop", fe_v, 0);
        chk("post_reset_state", thread_state, 0);
        cycle();

        // random traffic
        init_done = 1'b1;
        for (int k = 0; k < THR; k++) begin
            set_idle(); cmd_v = 1'b1; cmd_op = 3'd0; cmd_tid = TW'(k);
            cycle();
        end
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            init_done = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
                cmd_v   = 1'b1;
                cmd_tid = TW'($urandom_range(0, THR - 1));
                cmd_op  = 3'($urandom_range(0, 7));
                r64     = {$urandom(), $urandom()};
                cmd_npc = r64[VA-1:0];
            end
            fetch_yumi = ($urandom_range(0, 3) != 0);
            fe_ready   = ($urandom_range(0, 7) != 0);
            t = $urandom_range(0, THR - 1);
            if (inflight(t) > 0 && $urandom_range(0, 2) != 0) begin
                ret_v     = 1'b1;
                ret_tid   = TW'(t);
                ret_exc   = ($urandom_range(0, 9) == 0);
                r64       = {$urandom(), $urandom()};
                ret_pc    = r64[VA-1:0];
                ret_instr = $urandom();
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_controller_mt.md
# bp_fe_controller_mt

Multithreaded front-end fetch controller: the parametrised successor to the single-thread FE controller FSM. It holds one reset/wait/run/resume FSM per hardware thread and round-robin arbitrates I-cache fetch issue among eligible threads. It tracks per-thread in-flight fetch credits and discards stale returns after redirects or exceptions. It sits between the BE command queue, the I-cache/ITLB fetch pipe, and the FE queue.

## Interface
Parameters:
- threads_p, 2, number of hardware threads (≥1); tid_width = max(1, clog2(threads_p))
- vaddr_width_p, 39, virtual address width
- outstanding_p, 2, max in-flight fetches per thread (≥1); cnt_width = clog2(outstanding_p+1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- init_done_i  in  1  PC-gen/BTB init complete
- cmd_v_i  in  1  command valid
- cmd_tid_i  in  tid_width  command thread
- cmd_op_i  in  3  command: 0 state_reset, 1 pc_redirect, 2 fill_restart, 3 wait, 4 fence, 5 attaboy, 6–7 reserved
- cmd_npc_i  in  vaddr_width_p  target PC
- cmd_yumi_o  out  1  command consumed
- redirect_v_o / redirect_tid_o / redirect_npc_o  out  1 / tid_width / vaddr_width_p  PC-gen redirect
- fetch_v_o / fetch_tid_o  out  1 / tid_width  fetch request and selected thread
- fetch_yumi_i  in  1  fetch accepted by I-cache
- ret_v_i / ret_tid_i / ret_exc_i  in  1 / tid_width / 1  fetch return, thread, exception flag
- ret_pc_i / ret_instr_i  in  vaddr_width_p / 32  returned PC and instruction
- fe_queue_v_o / fe_queue_tid_o / fe_queue_exc_o  out  1 / tid_width / 1
- fe_queue_pc_o / fe_queue_instr_o  out  vaddr_width_p / 32  passthrough of ret_*
- fe_queue_ready_and_i  in  1  FE queue can accept
- thread_state_o  out  2*threads_p  per-thread state, thread t at bits [2t+1:2t]

## Operation
- Per-thread state encoding: RESET=0, WAIT=1, RUN=2, RESUME=3.
- Per-thread registers:
  - state
  - outstanding counter ocnt
  - drop counter dcnt (0..outstanding_p)
- Global register: round-robin pointer rr (last granted thread).
- Command handling (thread t = cmd_tid_i):
  - state_reset: consumed only when init_done_i=1. Then t→RESUME, dcnt[t] ← ocnt_n[t]. Otherwise held (cmd_yumi_o=0).
  - Any other op while t is in RESET: consumed and dropped, no effect.
  - pc_redirect, fill_restart: redirect_v_o=1, t→RUN, dcnt[t] ← ocnt_n[t].
  - wait, fence: t→WAIT, dcnt[t] ← ocnt_n[t]. fence also pulses redirect_v_o (I-cache invalidate path).
  - attaboy: consumed, no state change.
  - reserved ops: consumed, no effect.
- Thread eligibility for fetch: state ∈ {RUN, RESUME}, ocnt<outstanding_p, not the target of a non-attaboy command this cycle, and fe_queue_ready_and_i=1.
- Grant: first eligible thread in order rr+1, rr+2, … with wrap-around. fetch_v_o = any eligible. rr ← granted thread on fetch_yumi_i.
- Issue: on fetch_yumi_i, ocnt[granted]++. A RESUME thread moves to RUN.
- Return to thread r = ret_tid_i:
  - ocnt[r]-- on every return.
  - If dcnt[r]>0, or a non-attaboy command targets r in the same cycle: dropped, dcnt[r]-- (saturating at 0).
  - Otherwise forwarded: fe_queue_v_o=1.
  - Forwarded ret_exc_i=1: r→WAIT, dcnt[r] ← ocnt_n[r].
- ocnt_n = ocnt + issue − return, same-cycle net.
- Downstream contract: the FE queue accepts every forwarded return. This is guaranteed because issue is gated on ready.

## Timing
- Reset (async assert): all states RESET; ocnt, dcnt, rr=0; every output 0; thread_state_o=0.
- cmd_yumi_o, redirect_*, fetch_v_o/fetch_tid_o and fe_queue_* are combinational: zero latency from inputs and registered state.
- State, counter and pointer updates take effect at the next clk_i edge.
- Command and return for the same thread in one cycle: the command wins and the return is dropped.
- Issue and return for the same thread in one cycle: ocnt unchanged.
- ocnt never exceeds outstanding_p and never underflows. A return with ocnt=0 is a protocol error; assert in simulation.
- Reset mid-operation clears all credits. Returns arriving after reset are dropped: thread in RESET, ocnt=0.

## Test plan
- Reset then state_reset to t0 with init_done_i=0 → cmd_yumi_o=0. Raise init_done_i → yumi, t0=RESUME next cycle. First fetch_yumi_i → t0=RUN.
- Both threads in RUN, fetch_yumi_i every cycle → fetch_tid_o alternates 0,1,0,1. With outstanding_p=2 and no returns, fetch_v_o drops after 4 issues.
- t1 has 2 in flight; pc_redirect t1 npc=0x8000_0000 → redirect_v_o=1, redirect_npc_o=0x80000000. Next 2 t1 returns dropped (fe_queue_v_o=0); the 3rd is forwarded.
- t0 returns ret_exc_i=1 with 1 other in flight → forwarded with fe_queue_exc_o=1, t0=WAIT, next t0 return dropped, t0 never granted until redirect.
- fe_queue_ready_and_i=0 → fetch_v_o=0 for all threads. Attaboy → yumi, thread_state_o unchanged.
- Same-cycle wait cmd and return for t1 → return dropped, ocnt decremented, t1=WAIT. Async reset mid-burst → all outputs 0 immediately.
